// File: rtl/multi_level_priority_arbiter_pkg.sv
// Shared width helpers and boost-level constant for the multi-level priority arbiter.
package multi_level_priority_arbiter_pkg;

  function automatic int unsigned prio_width(input int unsigned num_levels);
    return (num_levels > 1) ? $clog2(num_levels) : 1;
  endfunction

  function automatic int unsigned age_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

  function automatic int unsigned req_log2(input int unsigned num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

  // Starved heads compete one level above the highest real priority.
  function automatic int unsigned boost_level(input int unsigned num_levels);
    return num_levels;
  endfunction

endpackage

// File: rtl/fifo_queue.sv
// Per-channel request queue; full/empty derive only from registered state.
module fifo_queue #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  push_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty_out,
  output logic                  full_out
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  do_push, do_pop;

  assign full_out  = (count == (AW+1)'(DEPTH));
  assign empty_out = (count == '0);
  assign do_push   = push_in & ~full_out;
  assign do_pop    = pop_in & ~empty_out;
  assign data_out  = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multi_level_priority_arbiter_rr_priority_select.sv
// Highest effective priority wins; ties resolved by round-robin scan after last_grant.
module rr_priority_select #(
  parameter int unsigned NUM_REQUEST = 4,
  parameter int unsigned PRIO_W      = 3,
  parameter int unsigned IDX_W       = 2
) (
  input  logic [NUM_REQUEST-1:0]        valid_in,
  input  logic [PRIO_W*NUM_REQUEST-1:0] prio_flat_in,
  input  logic [IDX_W-1:0]              last_grant_in,
  output logic [IDX_W-1:0]              winner_out,
  output logic                          any_valid_out
);
  logic [PRIO_W-1:0] prio_arr [NUM_REQUEST];

  for (genvar i = 0; i < NUM_REQUEST; i++) begin : g_unpack
    assign prio_arr[i] = prio_flat_in[i*PRIO_W +: PRIO_W];
  end

  int unsigned       idx;
  logic [IDX_W-1:0]  sel;
  logic [PRIO_W-1:0] best;

  // Strict '>' keeps the earliest candidate in scan order on ties.
  always_comb begin
    winner_out    = '0;
    any_valid_out = 1'b0;
    best          = '0;
    idx           = 0;
    sel           = '0;
    for (int unsigned k = 1; k <= NUM_REQUEST; k++) begin
      idx = 32'(last_grant_in) + k;
      if (idx >= NUM_REQUEST) idx = idx - NUM_REQUEST;
      sel = IDX_W'(idx);
      if (valid_in[sel] && (!any_valid_out || prio_arr[sel] > best)) begin
        any_valid_out = 1'b1;
        best          = prio_arr[sel];
        winner_out    = sel;
      end
    end
  end

endmodule

// File: rtl/multi_level_priority_arbiter.sv
// N-to-1 arbiter: per-channel queues, multi-level priority, round-robin ties,
// starvation boost, registered valid/ack output stage.
module multi_level_priority_arbiter
  import multi_level_priority_arbiter_pkg::*;
#(
  parameter int unsigned SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_REQUEST                  = 4,
  parameter int unsigned INPUT_QUEUE_SIZE             = 2,
  parameter int unsigned NUM_PRIORITY_LEVEL           = 4,
  parameter int unsigned STARVATION_LIMIT             = 15,
  parameter int unsigned PRIORITY_WIDTH               = prio_width(NUM_PRIORITY_LEVEL),
  parameter int unsigned NUM_REQUEST_LOG2             = req_log2(NUM_REQUEST)
) (
  input  logic                                             clk_in,
  input  logic                                             reset_in,
  input  logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_in,
  input  logic [NUM_REQUEST-1:0]                           request_valid_flatted_in,
  input  logic [PRIORITY_WIDTH*NUM_REQUEST-1:0]            request_priority_flatted_in,
  output logic [NUM_REQUEST-1:0]                           issue_ack_out,
  output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]          request_out,
  output logic [NUM_REQUEST_LOG2-1:0]                      request_source_out,
  output logic                                             request_valid_out,
  input  logic                                             issue_ack_in
);
  localparam int unsigned W     = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int unsigned PW    = PRIORITY_WIDTH;
  localparam int unsigned EW    = W + PW;
  localparam int unsigned EP_W  = PW + 1;
  localparam int unsigned AGE_W = age_width(STARVATION_LIMIT);
  localparam int unsigned NL2   = NUM_REQUEST_LOG2;

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVATION_LIMIT);
  localparam logic [EP_W-1:0]  BOOST   = EP_W'(boost_level(NUM_PRIORITY_LEVEL));
  localparam logic [NL2-1:0]   LAST_CH = NL2'(NUM_REQUEST - 1);

  logic [NUM_REQUEST-1:0]      q_full, q_empty, q_pop, head_valid;
  logic [EW-1:0]               q_head [NUM_REQUEST];
  logic [AGE_W-1:0]            age    [NUM_REQUEST];
  logic [EP_W*NUM_REQUEST-1:0] eff_prio_flat;
  logic [NL2-1:0]              last_grant, winner;
  logic                        any_valid, load;

  assign load          = ~request_valid_out | issue_ack_in;
  assign issue_ack_out = request_valid_flatted_in & ~q_full & {NUM_REQUEST{~reset_in}};

  for (genvar i = 0; i < NUM_REQUEST; i++) begin : g_ch
    fifo_queue #(
      .DATA_WIDTH(EW),
      .DEPTH     (INPUT_QUEUE_SIZE)
    ) u_queue (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .push_in  (issue_ack_out[i]),
      .data_in  ({request_priority_flatted_in[i*PW +: PW], request_flatted_in[i*W +: W]}),
      .pop_in   (q_pop[i]),
      .data_out (q_head[i]),
      .empty_out(q_empty[i]),
      .full_out (q_full[i])
    );
    assign head_valid[i] = ~q_empty[i];
    assign eff_prio_flat[i*EP_W +: EP_W] =
      (age[i] == AGE_MAX) ? BOOST : {1'b0, q_head[i][EW-1 -: PW]};
    assign q_pop[i] = load & any_valid & (winner == NL2'(i));
  end

  rr_priority_select #(
    .NUM_REQUEST(NUM_REQUEST),
    .PRIO_W     (EP_W),
    .IDX_W      (NL2)
  ) u_select (
    .valid_in     (head_valid),
    .prio_flat_in (eff_prio_flat),
    .last_grant_in(last_grant),
    .winner_out   (winner),
    .any_valid_out(any_valid)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      request_out        <= '0;
      request_source_out <= '0;
      request_valid_out  <= 1'b0;
      last_grant         <= LAST_CH;
    end else if (load) begin
      if (any_valid) begin
        request_out        <= q_head[winner][W-1:0];
        request_source_out <= winner;
        request_valid_out  <= 1'b1;
        last_grant         <= winner;
      end else begin
        request_out        <= '0;
        request_source_out <= '0;
        request_valid_out  <= 1'b0;
      end
    end
  end

  // Ages only move on load cycles so a held output does not count as a lost arbitration.
  always_ff @(posedge clk_in) begin
    for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
      if (reset_in) begin
        age[i] <= '0;
      end else if (load) begin
        if (!head_valid[i] || (winner == NL2'(i))) age[i] <= '0;
        else if (age[i] != AGE_MAX)                 age[i] <= age[i] + 1'b1;
      end
    end
  end

endmodule
